// File: rtl/coin_credit_fsm.sv
// Payment stage ahead of the dispenser: counts coins into credit, validates a
// selection against its price, hands off a paid command and pays back change.
module coin_credit_fsm #(
  parameter int CW         = 4,
  parameter int MAX_CREDIT = 15,
  parameter int PRICE0     = 5,
  parameter int PRICE1     = 7,
  parameter int PRICE2     = 10,
  parameter int PRICE3     = 12,
  parameter int CHG_PERIOD = 4,
  parameter int VEND_TO    = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    COIN,
  input  logic [1:0]    SEL,
  input  logic          SEL_V,
  input  logic          CANCEL,
  input  logic          DONE,
  output logic [CW-1:0] CREDIT,
  output logic          PAID,
  output logic [1:0]    PROD,
  output logic          CHG_PULSE,
  output logic          REJECT,
  output logic          LOW_CREDIT,
  output logic          FAULT,
  output logic [2:0]    STATE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_VEND   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int TW = $clog2(VEND_TO + 1);
  localparam int DW = (CHG_PERIOD > 1) ? $clog2(CHG_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(VEND_TO - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CHG_PERIOD - 1);
  localparam logic [CW:0]   CREDIT_CAP = (CW+1)'(MAX_CREDIT);

  logic [1:0]    coin_q;
  logic [TW-1:0] timer;
  logic [DW-1:0] div;

  logic [2:0]    state_n;
  logic [CW-1:0] credit_n;
  logic [1:0]    prod_n;
  logic [TW-1:0] timer_n;
  logic [DW-1:0] div_n;
  logic          chg_n;
  logic          rej_n;
  logic          low_n;

  logic          coin_evt;
  logic [2:0]    coin_val;
  logic [CW:0]   coin_sum;
  logic [CW:0]   sel_price;

  function automatic logic [CW:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    price_of = (CW+1)'(PRICE0);
      2'd1:    price_of = (CW+1)'(PRICE1);
      2'd2:    price_of = (CW+1)'(PRICE2);
      default: price_of = (CW+1)'(PRICE3);
    endcase
  endfunction

  // One event per insertion: only the idle-to-nonzero transition counts.
  assign coin_evt  = (coin_q == 2'b00) && (COIN != 2'b00);
  assign coin_sum  = {1'b0, CREDIT} + (CW+1)'(coin_val);
  assign sel_price = price_of(SEL);

  always_comb begin
    case (COIN)
      2'b01:   coin_val = 3'd1;
      2'b10:   coin_val = 3'd2;
      2'b11:   coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  always_comb begin
    state_n  = STATE;
    credit_n = CREDIT;
    prod_n   = PROD;
    timer_n  = timer;
    div_n    = div;
    chg_n    = 1'b0;
    rej_n    = 1'b0;
    low_n    = 1'b0;
    case (STATE)
      S_IDLE: begin
        if (coin_evt) begin
          credit_n = CW'(coin_val);
          state_n  = S_ACCUM;
        end
        low_n = SEL_V;
      end
      S_ACCUM: begin
        if (CANCEL) begin
          rej_n   = coin_evt;
          div_n   = '0;
          state_n = S_CHANGE;
        end else if (SEL_V) begin
          rej_n = coin_evt;
          if ({1'b0, CREDIT} >= sel_price) begin
            credit_n = CW'({1'b0, CREDIT} - sel_price);
            prod_n   = SEL;
            timer_n  = '0;
            state_n  = S_VEND;
          end else begin
            low_n = 1'b1;
          end
        end else if (coin_evt) begin
          if (coin_sum > CREDIT_CAP) rej_n = 1'b1;
          else                       credit_n = coin_sum[CW-1:0];
        end
      end
      S_VEND: begin
        rej_n = coin_evt;
        if (DONE) begin
          div_n   = '0;
          state_n = (CREDIT != '0) ? S_CHANGE : S_IDLE;
        end else if (timer == TIMER_LAST) begin
          state_n = S_FAULT;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_CHANGE: begin
        rej_n = coin_evt;
        // Zero credit covers both cancel-on-empty and the cycle after the last pulse.
        if (CREDIT == '0) begin
          state_n = S_IDLE;
        end else if (div == DIV_LAST) begin
          chg_n    = 1'b1;
          credit_n = CREDIT - CW'(1);
          div_n    = '0;
        end else begin
          div_n = div + DW'(1);
        end
      end
      S_FAULT: begin
        rej_n = coin_evt;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STATE      <= S_IDLE;
      CREDIT     <= '0;
      PROD       <= 2'b00;
      coin_q     <= 2'b00;
      timer      <= '0;
      div        <= '0;
      PAID       <= 1'b0;
      CHG_PULSE  <= 1'b0;
      REJECT     <= 1'b0;
      LOW_CREDIT <= 1'b0;
      FAULT      <= 1'b0;
    end else begin
      STATE      <= state_n;
      CREDIT     <= credit_n;
      PROD       <= prod_n;
      coin_q     <= COIN;
      timer      <= timer_n;
      div        <= div_n;
      PAID       <= (state_n == S_VEND);
      CHG_PULSE  <= chg_n;
      REJECT     <= rej_n;
      LOW_CREDIT <= low_n;
      FAULT      <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Self-checking bench for coin_credit_fsm: directed scenarios plus a randomized
// run scored against a transaction-level credit model.
module tb_coin_credit_fsm;

  localparam int CHG_PERIOD = 4;
  localparam int VEND_TO    = 255;
  localparam int MAX_CREDIT = 15;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] COIN = 2'b00;
  logic [1:0] SEL = 2'b00;
  logic       SEL_V = 1'b0;
  logic       CANCEL = 1'b0;
  logic       DONE = 1'b0;
  logic [3:0] CREDIT;
  logic       PAID;
  logic [1:0] PROD;
  logic       CHG_PULSE;
  logic       REJECT;
  logic       LOW_CREDIT;
  logic       FAULT;
  logic [2:0] STATE;

  int checks = 0;
  int passes = 0;
  int pulse_at[$];
  int credit_at[$];
  int price_tab[4] = '{5, 7, 10, 12};
  int coin_tab[4]  = '{0, 1, 2, 5};

  coin_credit_fsm dut (
    .CLK(CLK), .RESET(RESET), .COIN(COIN), .SEL(SEL), .SEL_V(SEL_V),
    .CANCEL(CANCEL), .DONE(DONE), .CREDIT(CREDIT), .PAID(PAID), .PROD(PROD),
    .CHG_PULSE(CHG_PULSE), .REJECT(REJECT), .LOW_CREDIT(LOW_CREDIT),
    .FAULT(FAULT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    COIN = 2'b00; SEL = 2'b00; SEL_V = 1'b0; CANCEL = 1'b0; DONE = 1'b0;
    RESET = 1'b0;
    cyc(); cyc();
    RESET = 1'b1;
    cyc();
  endtask

  // Insert one coin held for 'hold' cycles; returns REJECT/CREDIT right after the event edge.
  task automatic insert(input logic [1:0] code, input int hold, output logic rej, output logic [3:0] cr);
    COIN = code;
    cyc();
    rej = REJECT;
    cr  = CREDIT;
    for (int i = 1; i < hold; i++) cyc();
    COIN = 2'b00;
    cyc();
  endtask

  task automatic select(input int p);
    SEL = 2'(p); SEL_V = 1'b1;
    cyc();
    SEL_V = 1'b0;
  endtask

  // Called in the first cycle of CHANGE; records the cycle index and credit of each pulse.
  task automatic collect_change();
    pulse_at.delete();
    credit_at.delete();
    for (int k = 1; k <= 400; k++) begin
      cyc();
      if (CHG_PULSE === 1'b1) begin
        pulse_at.push_back(k);
        credit_at.push_back(int'(CREDIT));
      end
      if (STATE === 3'd0) break;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    cyc(); cyc();
    checks++; if ({CREDIT, PAID, PROD, CHG_PULSE, REJECT, LOW_CREDIT, FAULT, STATE} !== 15'd0)
      $display("FAIL reset_outputs: got %h want 0", {CREDIT, PAID, PROD, CHG_PULSE, REJECT, LOW_CREDIT, FAULT, STATE}); else passes++;
    RESET = 1'b1;
    cyc(); cyc();
    checks++; if (STATE !== 3'd0 || CREDIT !== 4'd0)
      $display("FAIL reset_idle: state %0d credit %0d want 0 0", STATE, CREDIT); else passes++;
  endtask

  task automatic test_purchase();
    logic rej; logic [3:0] cr;
    do_reset();
    insert(2'b11, 1, rej, cr);
    checks++; if (cr !== 4'd5 || rej !== 1'b0 || STATE !== 3'd1) $display("FAIL purchase_coin1: credit %0d rej %0d state %0d want 5 0 1", cr, rej, STATE); else passes++;
    insert(2'b11, 2, rej, cr);
    checks++; if (cr !== 4'd10) $display("FAIL purchase_coin2: credit %0d want 10", cr); else passes++;
    insert(2'b10, 1, rej, cr);
    checks++; if (cr !== 4'd12) $display("FAIL purchase_coin3: credit %0d want 12", cr); else passes++;
    select(2);
    checks++; if (PAID !== 1'b1 || PROD !== 2'd2 || CREDIT !== 4'd2 || STATE !== 3'd2)
      $display("FAIL purchase_vend: paid %0d prod %0d credit %0d state %0d want 1 2 2 2", PAID, PROD, CREDIT, STATE); else passes++;
    repeat (8) cyc();
    checks++; if (PAID !== 1'b1) $display("FAIL purchase_paid_hold: paid %0d want 1", PAID); else passes++;
    DONE = 1'b1; cyc(); DONE = 1'b0;
    checks++; if (PAID !== 1'b0 || STATE !== 3'd3) $display("FAIL purchase_done: paid %0d state %0d want 0 3", PAID, STATE); else passes++;
    collect_change();
    checks++; if (pulse_at.size() !== 2) $display("FAIL purchase_pulse_count: got %0d want 2", pulse_at.size()); else passes++;
    foreach (pulse_at[i]) begin
      checks++; if (pulse_at[i] !== CHG_PERIOD * (i + 1) || credit_at[i] !== 2 - (i + 1))
        $display("FAIL purchase_pulse: #%0d at cycle %0d credit %0d want cycle %0d credit %0d", i, pulse_at[i], credit_at[i], CHG_PERIOD * (i + 1), 2 - (i + 1)); else passes++;
    end
    checks++; if (STATE !== 3'd0 || CREDIT !== 4'd0) $display("FAIL purchase_end: state %0d credit %0d want 0 0", STATE, CREDIT); else passes++;
  endtask

  task automatic test_overflow();
    logic rej; logic [3:0] cr;
    do_reset();
    repeat (3) insert(2'b11, 1, rej, cr);
    checks++; if (cr !== 4'd15 || rej !== 1'b0) $display("FAIL overflow_fill: credit %0d rej %0d want 15 0", cr, rej); else passes++;
    insert(2'b01, 1, rej, cr);
    checks++; if (cr !== 4'd15 || rej !== 1'b1) $display("FAIL overflow_reject: credit %0d rej %0d want 15 1", cr, rej); else passes++;
    select(3);
    checks++; if (CREDIT !== 4'd3 || PROD !== 2'd3 || PAID !== 1'b1) $display("FAIL overflow_vend: credit %0d prod %0d paid %0d want 3 3 1", CREDIT, PROD, PAID); else passes++;
    DONE = 1'b1; cyc(); DONE = 1'b0;
    collect_change();
    checks++; if (pulse_at.size() !== 3) $display("FAIL overflow_pulse_count: got %0d want 3", pulse_at.size()); else passes++;
    foreach (pulse_at[i]) begin
      checks++; if (pulse_at[i] !== CHG_PERIOD * (i + 1) || credit_at[i] !== 3 - (i + 1))
        $display("FAIL overflow_pulse: #%0d at cycle %0d credit %0d want cycle %0d credit %0d", i, pulse_at[i], credit_at[i], CHG_PERIOD * (i + 1), 3 - (i + 1)); else passes++;
    end
    checks++; if (STATE !== 3'd0) $display("FAIL overflow_end: state %0d want 0", STATE); else passes++;
  endtask

  task automatic test_low_credit_cancel();
    logic rej; logic [3:0] cr;
    do_reset();
    insert(2'b11, 1, rej, cr);
    select(1);
    checks++; if (LOW_CREDIT !== 1'b1 || STATE !== 3'd1 || CREDIT !== 4'd5 || PAID !== 1'b0)
      $display("FAIL low_credit: low %0d state %0d credit %0d paid %0d want 1 1 5 0", LOW_CREDIT, STATE, CREDIT, PAID); else passes++;
    cyc();
    checks++; if (LOW_CREDIT !== 1'b0) $display("FAIL low_credit_width: low %0d want 0", LOW_CREDIT); else passes++;
    CANCEL = 1'b1; cyc(); CANCEL = 1'b0;
    checks++; if (STATE !== 3'd3) $display("FAIL cancel_enter: state %0d want 3", STATE); else passes++;
    collect_change();
    checks++; if (pulse_at.size() !== 5) $display("FAIL cancel_pulse_count: got %0d want 5", pulse_at.size()); else passes++;
    foreach (pulse_at[i]) begin
      checks++; if (pulse_at[i] !== CHG_PERIOD * (i + 1) || credit_at[i] !== 5 - (i + 1))
        $display("FAIL cancel_pulse: #%0d at cycle %0d credit %0d want cycle %0d credit %0d", i, pulse_at[i], credit_at[i], CHG_PERIOD * (i + 1), 5 - (i + 1)); else passes++;
    end
    checks++; if (STATE !== 3'd0 || CREDIT !== 4'd0) $display("FAIL cancel_end: state %0d credit %0d want 0 0", STATE, CREDIT); else passes++;
  endtask

  task automatic test_priority();
    logic rej; logic [3:0] cr;
    do_reset();
    insert(2'b11, 1, rej, cr);
    insert(2'b11, 1, rej, cr);
    CANCEL = 1'b1; SEL = 2'd0; SEL_V = 1'b1; COIN = 2'b01;
    cyc();
    CANCEL = 1'b0; SEL_V = 1'b0; COIN = 2'b00;
    checks++; if (REJECT !== 1'b1 || STATE !== 3'd3 || CREDIT !== 4'd10 || PAID !== 1'b0 || LOW_CREDIT !== 1'b0)
      $display("FAIL priority: rej %0d state %0d credit %0d paid %0d low %0d want 1 3 10 0 0", REJECT, STATE, CREDIT, PAID, LOW_CREDIT); else passes++;
    collect_change();
    checks++; if (pulse_at.size() !== 10) $display("FAIL priority_pulse_count: got %0d want 10", pulse_at.size()); else passes++;
    foreach (pulse_at[i]) begin
      checks++; if (pulse_at[i] !== CHG_PERIOD * (i + 1) || credit_at[i] !== 10 - (i + 1))
        $display("FAIL priority_pulse: #%0d at cycle %0d credit %0d want cycle %0d credit %0d", i, pulse_at[i], credit_at[i], CHG_PERIOD * (i + 1), 10 - (i + 1)); else passes++;
    end
  endtask

  task automatic test_timeout();
    logic rej; logic [3:0] cr;
    int n;
    bit paid_ok;
    do_reset();
    insert(2'b11, 1, rej, cr);
    insert(2'b11, 1, rej, cr);
    select(0);
    n = 0;
    paid_ok = (PAID === 1'b1);
    for (int k = 0; k < 400; k++) begin
      cyc();
      n++;
      if (FAULT === 1'b1) break;
      if (PAID !== 1'b1) paid_ok = 1'b0;
    end
    checks++; if (n !== VEND_TO) $display("FAIL timeout_cycles: fault after %0d want %0d", n, VEND_TO); else passes++;
    checks++; if (!paid_ok) $display("FAIL timeout_paid_hold: paid dropped %0d want 1", paid_ok); else passes++;
    checks++; if (FAULT !== 1'b1 || PAID !== 1'b0 || STATE !== 3'd4 || CREDIT !== 4'd5)
      $display("FAIL timeout_state: fault %0d paid %0d state %0d credit %0d want 1 0 4 5", FAULT, PAID, STATE, CREDIT); else passes++;
    insert(2'b10, 1, rej, cr);
    checks++; if (rej !== 1'b1 || cr !== 4'd5) $display("FAIL fault_coin: rej %0d credit %0d want 1 5", rej, cr); else passes++;
    DONE = 1'b1; CANCEL = 1'b1; SEL_V = 1'b1;
    cyc();
    DONE = 1'b0; CANCEL = 1'b0; SEL_V = 1'b0;
    cyc();
    checks++; if (FAULT !== 1'b1 || STATE !== 3'd4 || CREDIT !== 4'd5 || CHG_PULSE !== 1'b0)
      $display("FAIL fault_sticky: fault %0d state %0d credit %0d chg %0d want 1 4 5 0", FAULT, STATE, CREDIT, CHG_PULSE); else passes++;
    #2 RESET = 1'b0;
    #1;
    checks++; if (FAULT !== 1'b0 || STATE !== 3'd0 || CREDIT !== 4'd0)
      $display("FAIL fault_reset: fault %0d state %0d credit %0d want 0 0 0", FAULT, STATE, CREDIT); else passes++;
    cyc();
    RESET = 1'b1;
    cyc();
  endtask

  task automatic test_hold_and_reset();
    logic rej; logic [3:0] cr;
    int pulses;
    do_reset();
    COIN = 2'b10;
    repeat (20) cyc();
    checks++; if (CREDIT !== 4'd2 || STATE !== 3'd1) $display("FAIL hold_once: credit %0d state %0d want 2 1", CREDIT, STATE); else passes++;
    COIN = 2'b00;
    cyc();
    insert(2'b01, 1, rej, cr);
    checks++; if (cr !== 4'd3) $display("FAIL hold_add: credit %0d want 3", cr); else passes++;
    CANCEL = 1'b1; cyc(); CANCEL = 1'b0;
    cyc();
    #2 RESET = 1'b0;
    #1;
    checks++; if (CREDIT !== 4'd0 || STATE !== 3'd0 || CHG_PULSE !== 1'b0)
      $display("FAIL change_reset: credit %0d state %0d chg %0d want 0 0 0", CREDIT, STATE, CHG_PULSE); else passes++;
    cyc();
    RESET = 1'b1;
    pulses = 0;
    repeat (20) begin
      cyc();
      if (CHG_PULSE === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || STATE !== 3'd0) $display("FAIL change_reset_quiet: pulses %0d state %0d want 0 0", pulses, STATE); else passes++;
  endtask

  // Model tracks only the credit total; IDLE is simply credit==0.
  task automatic test_random();
    logic rej; logic [3:0] cr;
    logic exp_rej;
    int m, op, p, code, w;
    do_reset();
    m = 0;
    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(9, 0));
      if (op < 6) begin
        code = int'($urandom_range(3, 1));
        insert(2'(code), int'($urandom_range(4, 1)), rej, cr);
        exp_rej = (m + coin_tab[code] > MAX_CREDIT);
        if (!exp_rej) m += coin_tab[code];
        checks++; if (rej !== exp_rej || cr !== 4'(m))
          $display("FAIL rand_coin t%0d: rej %0d credit %0d want %0d %0d", t, rej, cr, exp_rej, m); else passes++;
      end else if (op < 9) begin
        p = int'($urandom_range(3, 0));
        select(p);
        if (m >= price_tab[p]) begin
          m -= price_tab[p];
          checks++; if (PAID !== 1'b1 || PROD !== 2'(p) || CREDIT !== 4'(m) || LOW_CREDIT !== 1'b0)
            $display("FAIL rand_buy t%0d: paid %0d prod %0d credit %0d want 1 %0d %0d", t, PAID, PROD, CREDIT, p, m); else passes++;
          w = int'($urandom_range(12, 0));
          repeat (w) cyc();
          DONE = 1'b1; cyc(); DONE = 1'b0;
          checks++; if (PAID !== 1'b0 || STATE !== (m > 0 ? 3'd3 : 3'd0))
            $display("FAIL rand_done t%0d: paid %0d state %0d want 0 %0d", t, PAID, STATE, (m > 0) ? 3 : 0); else passes++;
          if (m > 0) begin
            collect_change();
            checks++; if (pulse_at.size() !== m) $display("FAIL rand_buy_change t%0d: pulses %0d want %0d", t, pulse_at.size(), m); else passes++;
            foreach (pulse_at[i]) begin
              checks++; if (pulse_at[i] !== CHG_PERIOD * (i + 1))
                $display("FAIL rand_buy_spacing t%0d: #%0d at cycle %0d want %0d", t, i, pulse_at[i], CHG_PERIOD * (i + 1)); else passes++;
            end
          end
          m = 0;
        end else begin
          checks++; if (LOW_CREDIT !== 1'b1 || CREDIT !== 4'(m) || PAID !== 1'b0)
            $display("FAIL rand_low t%0d: low %0d credit %0d paid %0d want 1 %0d 0", t, LOW_CREDIT, CREDIT, PAID, m); else passes++;
          cyc();
        end
      end else begin
        CANCEL = 1'b1; cyc(); CANCEL = 1'b0;
        if (m == 0) begin
          checks++; if (STATE !== 3'd0 || CHG_PULSE !== 1'b0) $display("FAIL rand_cancel_idle t%0d: state %0d want 0", t, STATE); else passes++;
        end else begin
          collect_change();
          checks++; if (pulse_at.size() !== m || STATE !== 3'd0 || CREDIT !== 4'd0)
            $display("FAIL rand_cancel t%0d: pulses %0d state %0d credit %0d want %0d 0 0", t, pulse_at.size(), STATE, CREDIT, m); else passes++;
        end
        m = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_overflow();
    test_low_credit_cancel();
    test_priority();
    test_timeout();
    test_hold_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/coin_credit_fsm.md
Name: coin_credit_fsm

Overview:
Payment stage that sits directly upstream of the dispenser FSM. It detects coin insertions, accumulates credit and validates a product selection against a per-product price. On a valid purchase it hands the dispenser a paid/product command and waits for the dispenser's completion. It then pays back any remaining credit as unit change pulses.

Parameters:
CW, 4, credit register width in bits.
MAX_CREDIT, 15, largest credit value accepted; must be at most 2^CW-1.
PRICE0, 5, price of product 0 in credit units.
PRICE1, 7, price of product 1.
PRICE2, 10, price of product 2.
PRICE3, 12, price of product 3.
CHG_PERIOD, 4, cycles between change pulses; must be at least 2.
VEND_TO, 255, maximum cycles to wait for DONE in VEND.

Ports:
CLK  in  1  system clock; all state changes on its rising edge.
RESET  in  1  asynchronous, active-low reset.
COIN  in  2  coin sensor level, already synchronous to CLK: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
SEL  in  2  product index; sampled only when SEL_V=1.
SEL_V  in  1  one-cycle selection strobe.
CANCEL  in  1  one-cycle strobe requesting a refund.
DONE  in  1  one-cycle strobe from the dispenser: dispense complete.
CREDIT  out  CW  current credit.
PAID  out  1  high throughout VEND; drives the dispenser enable.
PROD  out  2  product latched at purchase; valid while PAID=1.
CHG_PULSE  out  1  one-cycle pulse; each pulse returns 1 unit.
REJECT  out  1  one-cycle pulse: coin refused.
LOW_CREDIT  out  1  one-cycle pulse: selection refused for insufficient credit.
FAULT  out  1  sticky; set on VEND timeout.
STATE  out  3  state code for debug/display.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE; CREDIT=0, PROD=0, coin_q=00, timers=0.
  - All pulse outputs 0; PAID=0, FAULT=0.
- Coin event:
  - coin_q holds COIN registered each cycle.
  - An event fires in a cycle where coin_q==00 and COIN!=00. Exactly one event per insertion, regardless of how long COIN is held.
  - Value is 1, 2 or 5 per the COIN code.
- State codes: IDLE=0, ACCUM=1, VEND=2, CHANGE=3, FAULT=4.
- IDLE:
  - Coin event: CREDIT<=value; go ACCUM.
  - SEL_V: LOW_CREDIT pulse.
  - CANCEL: ignored.
- ACCUM: per-cycle priority is CANCEL > SEL_V > coin; lower-priority events in the same cycle are dropped, and a dropped coin event gives a REJECT pulse.
  - CANCEL: go CHANGE.
  - SEL_V with CREDIT>=PRICE[SEL]: CREDIT<=CREDIT-PRICE; PROD<=SEL; go VEND. PAID rises the next cycle.
  - SEL_V with CREDIT<PRICE[SEL]: LOW_CREDIT pulse; stay.
  - Coin event: if CREDIT+value>MAX_CREDIT, REJECT pulse and credit unchanged; else CREDIT+=value. Compare at CW+1 bits so no wrap.
- VEND:
  - PAID=1; timer counts up from 0 on entry.
  - DONE: go CHANGE if CREDIT>0, else IDLE. PAID falls the next cycle.
  - Timer reaches VEND_TO with no DONE: go FAULT.
  - Coin events give a REJECT pulse; SEL_V and CANCEL are ignored.
- CHANGE:
  - Entry with CREDIT=0 (cancel on zero credit): go IDLE next cycle with no pulse.
  - Otherwise a divider counts from 0. When it reaches CHG_PERIOD-1: CHG_PULSE=1, CREDIT-=1, divider reset.
  - First pulse is CHG_PERIOD cycles after entry.
  - The cycle after the pulse that brings CREDIT to 0: go IDLE.
  - Coins give a REJECT pulse; SEL_V and CANCEL are ignored.
- FAULT:
  - FAULT=1, PAID=0; CREDIT frozen.
  - Every input is ignored, except that coin events still give a REJECT pulse.
  - Exit only by reset.
- Outputs:
  - All outputs are registered.
  - Pulses last exactly 1 cycle.
  - CREDIT never exceeds MAX_CREDIT and never underflows.
- Reset mid-VEND or mid-CHANGE: credit is lost and no further pulses appear. This is intended.

Test Plan:
1. Reset, then coins 5,5,2. CREDIT reads 5, 10, 12. SEL=2, SEL_V. Next cycle PAID=1, PROD=2, CREDIT=2. DONE at cycle 10. PAID=0; CHG_PULSE at CHG_PERIOD=4 and 8 cycles after CHANGE entry; CREDIT reaches 0; IDLE.
2. Coins 5,5,5 (CREDIT=15), then coin 1. REJECT pulse; CREDIT stays 15. SEL=3 (12) leaves 3; DONE; exactly 3 CHG_PULSE.
3. Credit 5, SEL=1 (price 7). LOW_CREDIT pulse, state stays ACCUM. CANCEL: 5 change pulses, spaced 4 cycles; IDLE.
4. Same cycle, CREDIT=10: CANCEL + SEL_V(0) + coin edge. CANCEL wins, REJECT pulses, no VEND; 10 change pulses.
5. Enter VEND, never assert DONE. After 255 cycles FAULT=1, PAID=0, STATE=4. Further coins pulse REJECT; DONE has no effect. RESET low clears everything.
6. Hold COIN=10 for 20 cycles: credit +2 once only. Assert RESET low during CHANGE with CREDIT=3: immediate CREDIT=0, IDLE, no pulses.
